token_exec: RTL and testbench

- Streaming statement executor that sits directly downstream of the lexer.
- Consumes 16-bit tokens {kind[15:8], value[7:0]} one per valid cycle, with no backpressure.
- Executes the language on the fly: `a/b/c = expr;`, `out expr;`, `if (expr) stmt`.
- Drives 8-bit results to the output port and raises DONE on the EOF token.

---
 rtl/token_pkg.sv | 24 ++
 rtl/token_exec.sv | 154 +++++++++++++++
 tb/tb_token_exec.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/token_pkg.sv
// token_pkg: token kinds, executor states and destination codes shared by the lexer and downstream stages.
package token_pkg;
  typedef enum logic [7:0] {
    K_NUM     = 8'h00,
    K_OUT     = 8'h01,
    K_A       = 8'h02,
    K_EQ      = 8'h03,
    K_B       = 8'h04,
    K_C       = 8'h05,
    K_IF      = 8'h06,
    K_LP      = 8'h07,
    K_RP      = 8'h08,
    K_PLUS    = 8'h09,
    K_MINUS   = 8'h0a,
    K_SEMI    = 8'h0b,
    K_EOF     = 8'h0c,
    K_ILLEGAL = 8'hff
  } kind_e;
  typedef enum logic [2:0] {S_STMT, S_EQ, S_LP, S_TERM, S_OP, S_SKIP, S_DONE, S_ERR} state_e;
  typedef enum logic [2:0] {D_A, D_B, D_C, D_OUT, D_COND} dest_e;
  function automatic kind_e decode_kind(input logic [7:0] code);
    return code <= 8'h0c ? kind_e'(code) : K_ILLEGAL;
  endfunction
endpackage

// File: rtl/token_exec.sv
// token_exec: streaming executor for assign/out/if statements fed one token per valid cycle.
module token_exec
  import token_pkg::*;
#(
  parameter bit ERR_RECOVER = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  output logic [7:0]  O_DATA,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  VAR_A,
  output logic [7:0]  VAR_B,
  output logic [7:0]  VAR_C
);
  state_e state_q, state_d;
  dest_e dest_q, dest_d;
  logic [7:0] acc_q, acc_d, a_q, a_d, b_q, b_d, c_q, c_d, o_data_q, o_data_d;
  logic sub_q, sub_d, o_valid_q, o_valid_d, done_q, done_d, error_q, error_d;
  kind_e kind;
  logic [7:0] tv;
  logic is_term, err;
  function automatic logic [7:0] term_val(input kind_e k, input logic [7:0] v, a, b, c);
    return k == K_A ? a : k == K_B ? b : k == K_C ? c : v;
  endfunction
  assign kind = decode_kind(I_DATA[15:8]);
  assign tv = term_val(kind, I_DATA[7:0], a_q, b_q, c_q);
  assign is_term = kind inside {K_NUM, K_A, K_B, K_C};
  always_comb begin
    state_d = state_q;
    dest_d = dest_q;
    acc_d = acc_q;
    sub_d = sub_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    o_valid_d = 1'b0;
    o_data_d = o_data_q;
    done_d = done_q;
    error_d = error_q;
    err = 1'b0;
    if (I_VALID) begin
      case (state_q)
        S_STMT:
          case (kind)
            K_A, K_B, K_C: begin
              dest_d = kind == K_A ? D_A : kind == K_B ? D_B : D_C;
              state_d = S_EQ;
            end
            K_OUT: begin
              dest_d = D_OUT;
              acc_d = '0;
              sub_d = 1'b0;
              state_d = S_TERM;
            end
            K_IF: state_d = S_LP;
            K_SEMI: state_d = S_STMT;
            K_EOF: begin
              done_d = 1'b1;
              state_d = S_DONE;
            end
            default: err = 1'b1;
          endcase
        S_EQ:
          if (kind == K_EQ) begin
            acc_d = '0;
            sub_d = 1'b0;
            state_d = S_TERM;
          end else err = 1'b1;
        S_LP:
          if (kind == K_LP) begin
            dest_d = D_COND;
            acc_d = '0;
            sub_d = 1'b0;
            state_d = S_TERM;
          end else err = 1'b1;
        S_TERM:
          if (is_term) begin
            acc_d = sub_q ? acc_q - tv : acc_q + tv;
            state_d = S_OP;
          end else err = 1'b1;
        S_OP:
          case (kind)
            K_PLUS, K_MINUS: begin
              sub_d = kind == K_MINUS;
              state_d = S_TERM;
            end
            K_SEMI:
              if (dest_q == D_COND) err = 1'b1;
              else begin
                a_d = dest_q == D_A ? acc_q : a_q;
                b_d = dest_q == D_B ? acc_q : b_q;
                c_d = dest_q == D_C ? acc_q : c_q;
                o_valid_d = dest_q == D_OUT;
                o_data_d = dest_q == D_OUT ? acc_q : o_data_q;
                state_d = S_STMT;
              end
            K_RP:
              if (dest_q != D_COND) err = 1'b1;
              else state_d = acc_q != '0 ? S_STMT : S_SKIP;
            default: err = 1'b1;
          endcase
        S_SKIP: begin
          state_d = kind == K_SEMI ? S_STMT : kind == K_EOF ? S_DONE : S_SKIP;
          done_d = done_q | (kind == K_EOF);
        end
        default: state_d = state_q;
      endcase
      // EOF always terminates, even when it is the offending token
      if (err) begin
        error_d = 1'b1;
        done_d = done_q | (kind == K_EOF);
        state_d = kind == K_EOF ? S_DONE : !ERR_RECOVER ? S_ERR : kind == K_SEMI ? S_STMT : S_SKIP;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_STMT;
      dest_q <= D_A;
      acc_q <= '0;
      sub_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      acc_q <= acc_d;
      sub_q <= sub_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      o_valid_q <= o_valid_d;
      o_data_q <= o_data_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign O_VALID = o_valid_q;
  assign O_DATA = o_data_q;
  assign DONE = done_q;
  assign ERROR = error_q;
  assign VAR_A = a_q;
  assign VAR_B = b_q;
  assign VAR_C = c_q;
endmodule

// File: tb/tb_token_exec.sv
// tb_token_exec: drives token programs into both recovery variants and compares against a recursive-descent interpreter.
module tb_token_exec;
  localparam int MAXN = 256;
  localparam logic [7:0] T_NUM = 8'h00, T_OUT = 8'h01, T_A = 8'h02, T_EQ = 8'h03, T_B = 8'h04, T_C = 8'h05,
    T_IF = 8'h06, T_LP = 8'h07, T_RP = 8'h08, T_PLUS = 8'h09, T_MINUS = 8'h0a, T_SEMI = 8'h0b, T_EOF = 8'h0c;
  localparam int NDIR = 9;
  localparam int DLEN [NDIR] = '{9, 9, 10, 14, 6, 1, 3, 7, 4};
  localparam logic [15:0] DIR [NDIR][14] = '{
    '{16'h0200, 16'h0300, 16'h0005, 16'h0b00, 16'h0100, 16'h0200, 16'h0900, 16'h0003, 16'h0b00, 0, 0, 0, 0, 0},
    '{16'h0400, 16'h0300, 16'h0002, 16'h0a00, 16'h0005, 16'h0b00, 16'h0100, 16'h0400, 16'h0b00, 0, 0, 0, 0, 0},
    '{16'h0600, 16'h0700, 16'h0000, 16'h0800, 16'h0100, 16'h0007, 16'h0b00, 16'h0100, 16'h0009, 16'h0b00, 0, 0, 0, 0},
    '{16'h0600, 16'h0700, 16'h0001, 16'h0800, 16'h0600, 16'h0700, 16'h0000, 16'h0800, 16'h0100, 16'h0001,
      16'h0b00, 16'h0100, 16'h0002, 16'h0b00},
    '{16'h0200, 16'h0005, 16'h0b00, 16'h0100, 16'h0004, 16'h0b00, 0, 0, 0, 0, 0, 0, 0, 0},
    '{16'h0c00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{16'h0100, 16'h0001, 16'h0c00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{16'h0200, 16'h0300, 16'h0005, 16'h0b00, 16'h0200, 16'h0300, 16'h0003, 0, 0, 0, 0, 0, 0, 0},
    '{16'h0100, 16'h0200, 16'h0b00, 16'h0c00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic ov [2], dn [2], er [2];
  logic [7:0] od [2], va [2], vb [2], vc [2];
  int n_checks = 0, n_errors = 0, cur_prog = 0;
  logic [15:0] prog [$];
  logic [7:0] sa [2][MAXN], sb [2][MAXN], sc [2][MAXN], so [2][MAXN];
  bit sv [2][MAXN], sd [2][MAXN], se [2][MAXN];
  int mp, mn, mr;
  bit mfail, mhalt, mdn, mer;
  logic [7:0] ma, mb, mc, mo;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    token_exec #(.ERR_RECOVER(g == 1)) u_dut (
      .CLK(clk), .RST(rst), .I_VALID(i_valid), .I_DATA(i_data),
      .O_VALID(ov[g]), .O_DATA(od[g]), .DONE(dn[g]), .ERROR(er[g]),
      .VAR_A(va[g]), .VAR_B(vb[g]), .VAR_C(vc[g])
    );
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] kd(input int i);
    return prog[i][15:8];
  endfunction

  // Record the architectural state after consuming token mp.
  task automatic take(input bit o);
    sa[mr][mp] = ma;
    sb[mr][mp] = mb;
    sc[mr][mp] = mc;
    so[mr][mp] = mo;
    sv[mr][mp] = o;
    sd[mr][mp] = mdn;
    se[mr][mp] = mer;
    mp++;
  endtask

  task automatic skip();
    while (mp < mn) begin
      if (kd(mp) == T_SEMI) begin
        take(0);
        return;
      end
      if (kd(mp) == T_EOF) begin
        mdn = 1;
        mhalt = 1;
        take(0);
        return;
      end
      take(0);
    end
  endtask

  task automatic bad();
    logic [7:0] k;
    k = kd(mp);
    mer = 1;
    mfail = 1;
    if (k == T_EOF) begin
      mdn = 1;
      mhalt = 1;
      take(0);
    end else begin
      take(0);
      if (mr == 0) mhalt = 1;
      else if (k != T_SEMI) skip();
    end
  endtask

  task automatic term(output logic [7:0] v);
    logic [7:0] k;
    v = '0;
    if (mp >= mn) begin
      mfail = 1;
      return;
    end
    k = kd(mp);
    if (k == T_NUM) v = prog[mp][7:0];
    else if (k == T_A) v = ma;
    else if (k == T_B) v = mb;
    else if (k == T_C) v = mc;
    else begin
      bad();
      return;
    end
    take(0);
  endtask

  task automatic expr(output logic [7:0] v);
    logic [7:0] t;
    bit s;
    term(v);
    while (!mfail && mp < mn && (kd(mp) == T_PLUS || kd(mp) == T_MINUS)) begin
      s = kd(mp) == T_MINUS;
      take(0);
      term(t);
      if (!mfail) v = s ? v - t : v + t;
    end
  endtask

  task automatic expect_tok(input logic [7:0] k);
    if (mp >= mn) mfail = 1;
    else if (kd(mp) != k) bad();
    else take(0);
  endtask

  task automatic stmt();
    logic [7:0] k, v;
    mfail = 0;
    k = kd(mp);
    if (k == T_SEMI) take(0);
    else if (k == T_EOF) begin
      mdn = 1;
      mhalt = 1;
      take(0);
    end else if (k == T_IF) begin
      take(0);
      expect_tok(T_LP);
      if (mfail) return;
      expr(v);
      if (mfail) return;
      expect_tok(T_RP);
      if (!mfail && v == 0) skip();
    end else if (k == T_A || k == T_B || k == T_C || k == T_OUT) begin
      take(0);
      if (k != T_OUT) begin
        expect_tok(T_EQ);
        if (mfail) return;
      end
      expr(v);
      if (mfail || mp >= mn) return;
      if (kd(mp) != T_SEMI) begin
        bad();
        return;
      end
      if (k == T_A) ma = v;
      if (k == T_B) mb = v;
      if (k == T_C) mc = v;
      if (k == T_OUT) mo = v;
      take(k == T_OUT);
    end else bad();
  endtask

  task automatic run_model(input int r);
    mr = r;
    mp = 0;
    mn = prog.size();
    {ma, mb, mc, mo} = '0;
    {mdn, mer, mhalt} = '0;
    while (mp < mn && !mhalt) stmt();
    while (mp < mn) take(0);
  endtask

  function automatic logic [15:0] tk(input logic [7:0] k);
    return {k, 8'($urandom)};
  endfunction

  task automatic gen_term();
    int c = $urandom_range(0, 5);
    if (c < 3) prog.push_back({T_NUM, $urandom_range(0, 2) == 0 ? 8'h00 : 8'($urandom)});
    else prog.push_back(tk(c == 3 ? T_A : c == 4 ? T_B : T_C));
  endtask

  task automatic gen_expr();
    gen_term();
    repeat ($urandom_range(0, 2)) begin
      prog.push_back(tk($urandom_range(0, 1) ? T_PLUS : T_MINUS));
      gen_term();
    end
  endtask

  task automatic gen_simple();
    int c = $urandom_range(0, 3);
    if (c == 0) prog.push_back(tk(T_OUT));
    else begin
      prog.push_back(tk(c == 1 ? T_A : c == 2 ? T_B : T_C));
      prog.push_back(tk(T_EQ));
    end
    gen_expr();
    prog.push_back(tk(T_SEMI));
  endtask

  task automatic gen();
    int c, idx;
    prog.delete();
    repeat ($urandom_range(3, 12)) begin
      c = $urandom_range(0, 9);
      if (c == 0) prog.push_back(tk($urandom_range(0, 3) == 0 ? 8'h5a : 8'($urandom_range(0, 12))));
      else if (c == 1) prog.push_back(tk(T_SEMI));
      else if (c < 4) begin
        prog.push_back(tk(T_IF));
        prog.push_back(tk(T_LP));
        gen_expr();
        prog.push_back(tk(T_RP));
        if ($urandom_range(0, 3) == 0) begin
          prog.push_back(tk(T_IF));
          prog.push_back(tk(T_LP));
          gen_expr();
          prog.push_back(tk(T_RP));
        end
        gen_simple();
      end else gen_simple();
    end
    if ($urandom_range(0, 2) == 0) begin
      idx = $urandom_range(0, prog.size() - 1);
      prog[idx] = tk(8'($urandom_range(0, 14)));
    end
    if ($urandom_range(0, 4) != 0) prog.push_back(tk(T_EOF));
    repeat (2) prog.push_back(tk(8'($urandom_range(0, 12))));
  endtask

  task automatic cmp(input int i, input bit ov_ok);
    for (int r = 0; r < 2; r++) begin
      string p = $sformatf("p%0d r%0d t%0d", cur_prog, r, i);
      check({p, " O_VALID"}, 8'(ov[r]), i < 0 ? 8'h00 : 8'(sv[r][i] & ov_ok));
      check({p, " O_DATA"}, od[r], i < 0 ? 8'h00 : so[r][i]);
      check({p, " DONE"}, 8'(dn[r]), i < 0 ? 8'h00 : 8'(sd[r][i]));
      check({p, " ERROR"}, 8'(er[r]), i < 0 ? 8'h00 : 8'(se[r][i]));
      check({p, " VAR_A"}, va[r], i < 0 ? 8'h00 : sa[r][i]);
      check({p, " VAR_B"}, vb[r], i < 0 ? 8'h00 : sb[r][i]);
      check({p, " VAR_C"}, vc[r], i < 0 ? 8'h00 : sc[r][i]);
    end
  endtask

  // Reset lands between clock edges so its effect is visible before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 cmp(-1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 cmp(-1, 0);
  endtask

  task automatic drive();
    for (int i = 0; i < prog.size(); i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data = prog[i];
      @(posedge clk);
      #1 cmp(i, 1);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(negedge clk);
          i_valid = 1'b0;
          i_data = 16'($urandom);
          @(posedge clk);
          #1 cmp(i, 0);
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    for (int t = 0; t < NDIR + 40; t++) begin
      cur_prog = t;
      if (t < NDIR) begin
        prog.delete();
        for (int i = 0; i < DLEN[t]; i++) prog.push_back(DIR[t][i]);
      end else gen();
      run_model(0);
      run_model(1);
      do_reset();
      drive();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
